hv_cmd_fetch: RTL and testbench

Command-processor-side fetch engine for the HV command queue. Requests one 256-bit CDB at a time over the queue's 64-bit `cmd_request`/`cmd_oe`/`cmd_out` interface and reassembles it from four beats. Decodes the CDB, allocates a TBM address, and writes that address back on the queue's `tbm_*` port. Presents the command downstream with a valid/ready handshake and drives every status update into the queue's `op_index`/`cmd_op_status` port.

---
 rtl/hv_cmd_fetch.sv | 208 ++++++++++++++++++++
 tb/tb_hv_cmd_fetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_cmd_fetch.sv
// HV command fetch engine: pulls one 256-bit CDB as four beats from the command
// queue, decodes it, allocates a TBM slot address and presents it downstream.
module hv_cmd_fetch #(
  parameter int          CMD_IO_WIDTH   = 64,
  parameter logic [31:0] TBM_BASE       = 32'h0000_0000,
  parameter int          TBM_SLOT_SHIFT = 12,
  parameter int          FETCH_TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cq_cout_ready,
  output logic                    cmd_request,
  input  logic                    cmd_oe,
  input  logic [CMD_IO_WIDTH-1:0] cmd_out,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [7:0]              cmd_index,
  output logic [7:0]              cmd_tag,
  output logic [7:0]              cmd_opcode,
  output logic [31:0]             cmd_lba,
  output logic [31:0]             cmd_len,
  output logic [31:0]             cmd_tbm_addr,
  output logic                    tbm_ie,
  output logic [7:0]              tbm_index,
  output logic [31:0]             tbm_address,
  output logic [7:0]              op_index,
  output logic [7:0]              cmd_op_status,
  input  logic                    done_ie,
  input  logic [7:0]              done_index,
  input  logic                    done_is_write,
  output logic                    done_ready,
  output logic                    fetch_timeout,
  output logic                    cks_drop,
  output logic [2:0]              dbg_state
);

  localparam int          CDB_W  = 4 * CMD_IO_WIDTH;
  localparam int          TW     = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [7:0]  OP_WRITE      = 8'h02;
  localparam logic [7:0]  ST_CKS_ERROR  = 8'd1;
  localparam logic [7:0]  ST_H2M        = 8'd4;
  localparam logic [7:0]  ST_Q2S        = 8'd5;
  localparam logic [7:0]  ST_READ_DONE  = 8'd6;
  localparam logic [7:0]  ST_WRITE_DONE = 8'd7;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_COLLECT = 3'd2,
    S_DECODE  = 3'd3,
    S_PRESENT = 3'd4
  } state_t;

  state_t           state;
  logic [CDB_W-1:0] cdb;
  logic [1:0]       beat_cnt;
  logic [TW-1:0]    timer;

  assign dbg_state = state;

  // Decoded fields of the assembled CDB.
  logic [7:0]  dec_opcode, dec_tag, dec_index, dec_cks;
  logic [31:0] dec_lba, dec_len, dec_addr;

  assign dec_opcode = cdb[7:0];
  assign dec_tag    = cdb[15:8];
  assign dec_index  = cdb[23:16];
  assign dec_cks    = cdb[31:24];
  assign dec_lba    = cdb[95:64];
  assign dec_len    = cdb[127:96];
  assign dec_addr   = TBM_BASE + (32'(dec_index) << TBM_SLOT_SHIFT);

  logic unused_cdb;
  assign unused_cdb = ^{cdb[CDB_W-1:128], cdb[63:32]};

  // Downstream handshake: cmd_valid is held with stable cmd_* fields until a
  // cycle in which cmd_ready is also high; that edge transfers the command.
  logic hs;
  assign hs = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cdb           <= '0;
      beat_cnt      <= '0;
      timer         <= '0;
      cmd_request   <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_index     <= '0;
      cmd_tag       <= '0;
      cmd_opcode    <= '0;
      cmd_lba       <= '0;
      cmd_len       <= '0;
      cmd_tbm_addr  <= '0;
      tbm_ie        <= 1'b0;
      tbm_index     <= '0;
      tbm_address   <= '0;
      fetch_timeout <= 1'b0;
      cks_drop      <= 1'b0;
    end else begin
      cmd_request   <= 1'b0;
      tbm_ie        <= 1'b0;
      fetch_timeout <= 1'b0;
      cks_drop      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cq_cout_ready && !cmd_oe) begin
            cmd_request <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          beat_cnt <= '0;
          timer    <= '0;
          state    <= S_COLLECT;
        end
        S_COLLECT: begin
          if (cmd_oe) begin
            cdb[int'(beat_cnt) * CMD_IO_WIDTH +: CMD_IO_WIDTH] <= cmd_out;
            timer    <= '0;
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) state <= S_DECODE;
          end else if (timer == TW'(FETCH_TIMEOUT - 2)) begin
            // The request cycle counts as the first idle cycle, so the pulse
            // lands FETCH_TIMEOUT cycles after cmd_request.
            fetch_timeout <= 1'b1;
            cdb           <= '0;
            state         <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DECODE: begin
          if (dec_cks == ST_CKS_ERROR) begin
            cks_drop <= 1'b1;
            state    <= S_IDLE;
          end else begin
            tbm_ie       <= 1'b1;
            tbm_index    <= dec_index;
            tbm_address  <= dec_addr;
            cmd_valid    <= 1'b1;
            cmd_index    <= dec_index;
            cmd_tag      <= dec_tag;
            cmd_opcode   <= dec_opcode;
            cmd_lba      <= dec_lba;
            cmd_len      <= dec_len;
            cmd_tbm_addr <= dec_addr;
            state        <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (hs) begin
            cmd_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status port: handshake update wins; a colliding completion waits one
  // cycle in buf_* and blocks further completions while it waits.
  logic       buf_valid;
  logic [7:0] buf_index;
  logic [7:0] buf_status;
  logic       done_acc, buf_issue, buf_load, buf_next;
  logic [7:0] done_status;

  always_comb begin
    done_acc    = done_ie && done_ready;
    done_status = done_is_write ? ST_WRITE_DONE : ST_READ_DONE;
    buf_issue   = buf_valid && !hs;
    buf_load    = done_acc && (hs || buf_valid);
    buf_next    = buf_load || (buf_valid && !buf_issue);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_index      <= '0;
      cmd_op_status <= '0;
      buf_valid     <= 1'b0;
      buf_index     <= '0;
      buf_status    <= '0;
      done_ready    <= 1'b1;
    end else begin
      op_index      <= '0;
      cmd_op_status <= '0;
      if (hs) begin
        op_index      <= cmd_index;
        cmd_op_status <= (cmd_opcode == OP_WRITE) ? ST_H2M : ST_Q2S;
      end else if (buf_issue) begin
        op_index      <= buf_index;
        cmd_op_status <= buf_status;
      end else if (done_acc) begin
        op_index      <= done_index;
        cmd_op_status <= done_status;
      end
      if (buf_load) begin
        buf_index  <= done_index;
        buf_status <= done_status;
      end
      buf_valid  <= buf_next;
      done_ready <= !buf_next;
    end
  end

endmodule

// File: tb/tb_hv_cmd_fetch.sv
// Directed bench for hv_cmd_fetch: table of CDB vectors plus hand-written
// sequences for timeout, stall, status collision and mid-fetch reset.
module tb_hv_cmd_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        cq_cout_ready;
  logic        cmd_request;
  logic        cmd_oe;
  logic [63:0] cmd_out;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_index, cmd_tag, cmd_opcode;
  logic [31:0] cmd_lba, cmd_len, cmd_tbm_addr;
  logic        tbm_ie;
  logic [7:0]  tbm_index;
  logic [31:0] tbm_address;
  logic [7:0]  op_index;
  logic [7:0]  cmd_op_status;
  logic        done_ie;
  logic [7:0]  done_index;
  logic        done_is_write;
  logic        done_ready;
  logic        fetch_timeout;
  logic        cks_drop;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  hv_cmd_fetch dut (
    .clk(clk), .reset(reset), .cq_cout_ready(cq_cout_ready),
    .cmd_request(cmd_request), .cmd_oe(cmd_oe), .cmd_out(cmd_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_tag(cmd_tag), .cmd_opcode(cmd_opcode),
    .cmd_lba(cmd_lba), .cmd_len(cmd_len), .cmd_tbm_addr(cmd_tbm_addr),
    .tbm_ie(tbm_ie), .tbm_index(tbm_index), .tbm_address(tbm_address),
    .op_index(op_index), .cmd_op_status(cmd_op_status),
    .done_ie(done_ie), .done_index(done_index), .done_is_write(done_is_write),
    .done_ready(done_ready), .fetch_timeout(fetch_timeout),
    .cks_drop(cks_drop), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] b0, b1, b2, b3;
    bit          drop;
    logic [7:0]  idx, tag, op;
    logic [31:0] lba, len, addr;
    logic [7:0]  st;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full fetch of vecs[v]; beats start 2 cycles after cmd_request.
  task automatic run_fetch(input int v, input int stall, input bit collide);
    bit got;
    logic [127:0] exp_fields;
    got = 1'b0;
    cq_cout_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (cmd_request) got = 1'b1;
    end
    cq_cout_ready = 1'b0;
    chk($sformatf("v%0d_req_seen", v), 128'(got), 128'd1);
    if (!got) return;
    tick();
    chk($sformatf("v%0d_req_one_cycle", v), 128'(cmd_request), 128'd0);
    tick();
    cmd_oe = 1'b1; cmd_out = vecs[v].b0; tick();
    cmd_out = vecs[v].b1; tick();
    cmd_out = vecs[v].b2; tick();
    cmd_out = vecs[v].b3; tick();
    cmd_oe = 1'b0;
    chk($sformatf("v%0d_decode_state", v), 128'({dbg_state, cmd_valid}), 128'({3'd3, 1'b0}));
    tick();
    if (vecs[v].drop) begin
      chk($sformatf("v%0d_drop_pulse", v),
          128'({cks_drop, tbm_ie, cmd_valid, dbg_state, cmd_op_status}),
          128'({1'b1, 1'b0, 1'b0, 3'd0, 8'd0}));
      tick();
      chk($sformatf("v%0d_drop_after", v),
          128'({cks_drop, tbm_ie, cmd_valid, dbg_state, cmd_op_status}),
          128'({1'b0, 1'b0, 1'b0, 3'd0, 8'd0}));
      return;
    end
    chk($sformatf("v%0d_tbm", v), 128'({tbm_ie, tbm_index, tbm_address}),
        128'({1'b1, vecs[v].idx, vecs[v].addr}));
    exp_fields = 128'({1'b1, vecs[v].idx, vecs[v].tag, vecs[v].op,
                       vecs[v].lba, vecs[v].len, vecs[v].addr});
    chk($sformatf("v%0d_cmd_fields", v),
        128'({cmd_valid, cmd_index, cmd_tag, cmd_opcode, cmd_lba, cmd_len, cmd_tbm_addr}),
        exp_fields);
    for (int s = 0; s < stall; s++) begin
      cmd_oe = 1'b1;
      cmd_out = {32'hA5A5_0000 + 32'(s), 32'h0101_FF01};
      tick();
      chk($sformatf("v%0d_stall%0d", v, s),
          128'({cmd_valid, cmd_index, cmd_tag, cmd_opcode, cmd_lba, cmd_len, cmd_tbm_addr}),
          exp_fields);
      chk($sformatf("v%0d_stall%0d_quiet", v, s), 128'({tbm_ie, cmd_op_status}), 128'd0);
    end
    cmd_oe = 1'b0;
    cmd_ready = 1'b1;
    if (collide) begin
      chk("collide_done_ready_pre", 128'(done_ready), 128'd1);
      done_ie = 1'b1; done_index = 8'd3; done_is_write = 1'b1;
    end
    tick();
    cmd_ready = 1'b0;
    done_ie = 1'b0;
    chk($sformatf("v%0d_status", v), 128'({op_index, cmd_op_status}),
        128'({vecs[v].idx, vecs[v].st}));
    chk($sformatf("v%0d_after_hs", v), 128'({cmd_valid, tbm_ie, dbg_state}), 128'd0);
    if (collide) begin
      chk("collide_done_ready_low", 128'(done_ready), 128'd0);
      tick();
      chk("collide_buffered_status", 128'({op_index, cmd_op_status, done_ready}),
          128'({8'd3, 8'd7, 1'b1}));
    end
    tick();
    chk($sformatf("v%0d_status_pulse_end", v), 128'(cmd_op_status), 128'd0);
  endtask

  initial begin
    bit got;
    bit early;

    vecs[0] = '{64'h0000_0000_0005_0502, 64'h0000_0010_0000_1000, 64'h0, 64'h0,
                1'b0, 8'h05, 8'h05, 8'h02, 32'h0000_1000, 32'h0000_0010, 32'h0000_5000, 8'd4};
    vecs[1] = '{64'h0000_0000_0200_0502, 64'h0000_0010_0000_1000, 64'h0, 64'h0,
                1'b0, 8'h00, 8'h05, 8'h02, 32'h0000_1000, 32'h0000_0010, 32'h0000_0000, 8'd4};
    vecs[2] = '{64'h0000_0000_03FF_2A01, 64'hDEAD_BEEF_0000_0040, 64'h1111, 64'h2222,
                1'b0, 8'hFF, 8'h2A, 8'h01, 32'h0000_0040, 32'hDEAD_BEEF, 32'h000F_F000, 8'd5};
    vecs[3] = '{64'hFFFF_FFFF_0080_117E, 64'h1234_5678_9ABC_DEF0, 64'hFFFF, 64'hEEEE,
                1'b0, 8'h80, 8'h11, 8'h7E, 32'h9ABC_DEF0, 32'h1234_5678, 32'h0008_0000, 8'd5};
    vecs[4] = '{64'h0000_0000_0105_0502, 64'h0000_0010_0000_1000, 64'h0, 64'h0,
                1'b1, 8'h05, 8'h05, 8'h02, 32'h0000_1000, 32'h0000_0010, 32'h0000_5000, 8'd0};
    vecs[5] = '{64'h0000_0000_0001_0002, 64'h0, 64'h0, 64'h0,
                1'b0, 8'h01, 8'h00, 8'h02, 32'h0, 32'h0, 32'h0000_1000, 8'd4};
    vecs[6] = '{64'h0000_0000_0007_0901, 64'h0000_0200_0000_0300, 64'h0, 64'h0,
                1'b0, 8'h07, 8'h09, 8'h01, 32'h0000_0300, 32'h0000_0200, 32'h0000_7000, 8'd5};

    reset = 1'b1; cq_cout_ready = 1'b0; cmd_oe = 1'b0; cmd_out = '0; cmd_ready = 1'b0;
    done_ie = 1'b0; done_index = '0; done_is_write = 1'b0;
    tick(); tick();
    chk("reset_outputs",
        128'({cmd_request, cmd_valid, tbm_ie, fetch_timeout, cks_drop, done_ready,
              dbg_state, op_index, cmd_op_status, tbm_index, tbm_address}),
        128'({5'd0, 1'b1, 3'd0, 8'd0, 8'd0, 8'd0, 32'd0}));
    chk("reset_cmd_fields",
        128'({cmd_index, cmd_tag, cmd_opcode, cmd_lba, cmd_len, cmd_tbm_addr}), 128'd0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) run_fetch(v, 0, 1'b0);

    // Fetch with no beats at all.
    got = 1'b0;
    cq_cout_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (cmd_request) got = 1'b1;
    end
    cq_cout_ready = 1'b0;
    chk("to_req_seen", 128'(got), 128'd1);
    early = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (fetch_timeout) early = 1'b1;
    end
    chk("to_no_early_pulse", 128'(early), 128'd0);
    tick();
    chk("to_pulse_at_16", 128'({fetch_timeout, dbg_state}), 128'({1'b1, 3'd0}));
    tick();
    chk("to_pulse_one_cycle", 128'({fetch_timeout, cmd_valid, tbm_ie}), 128'd0);

    // Two beats then silence.
    got = 1'b0;
    cq_cout_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (cmd_request) got = 1'b1;
    end
    cq_cout_ready = 1'b0;
    chk("partial_req_seen", 128'(got), 128'd1);
    tick(); tick();
    cmd_oe = 1'b1; cmd_out = 64'h0000_0000_00AA_BB02; tick();
    cmd_out = 64'h0000_0001_0000_0002; tick();
    cmd_oe = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (fetch_timeout) got = 1'b1;
      if (tbm_ie || cmd_valid) got = 1'b0;
    end
    chk("partial_timeout", 128'({got, dbg_state}), 128'({1'b1, 3'd0}));
    run_fetch(0, 0, 1'b0);

    // Downstream stall with stray beats, then status collision.
    run_fetch(2, 10, 1'b0);
    run_fetch(6, 0, 1'b1);

    // Stand-alone completions.
    done_ie = 1'b1; done_index = 8'h42; done_is_write = 1'b0;
    tick();
    done_ie = 1'b0;
    chk("done_read", 128'({op_index, cmd_op_status, done_ready}), 128'({8'h42, 8'd6, 1'b1}));
    done_ie = 1'b1; done_index = 8'hFF; done_is_write = 1'b1;
    tick();
    done_ie = 1'b0;
    chk("done_write", 128'({op_index, cmd_op_status, done_ready}), 128'({8'hFF, 8'd7, 1'b1}));
    tick();
    chk("done_pulse_end", 128'(cmd_op_status), 128'd0);

    // Reset asserted while beat 2 is on the bus.
    got = 1'b0;
    cq_cout_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (cmd_request) got = 1'b1;
    end
    cq_cout_ready = 1'b0;
    chk("rst_req_seen", 128'(got), 128'd1);
    tick(); tick();
    cmd_oe = 1'b1; cmd_out = 64'h0000_0000_0033_4402; tick();
    cmd_out = 64'h0000_0002_0000_0003; tick();
    cmd_out = 64'h5555_5555_5555_5555;
    chk("rst_pre_state", 128'(dbg_state), 128'd2);
    reset = 1'b1;
    #1;
    chk("rst_mid_fetch",
        128'({cmd_request, cmd_valid, tbm_ie, fetch_timeout, cks_drop, done_ready,
              dbg_state, cmd_op_status, tbm_address}),
        128'({5'd0, 1'b1, 3'd0, 8'd0, 32'd0}));
    cmd_oe = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_no_pulses", 128'({fetch_timeout, cks_drop, tbm_ie, dbg_state}), 128'd0);
    run_fetch(3, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
